// File: rtl/eth_pkt_buffer.sv
// Store-and-forward Ethernet packet buffer: classifies, commits and forwards whole packets.
// Optional statistics counters are enabled with `define ETH_PKT_BUF_STATS_EN.
module eth_pkt_buffer #(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] PORTA_ADDR = 32'h0000_ABCD,
    parameter logic [31:0] PORTB_ADDR = 32'h0000_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inWrEn,
    input  logic [33:0] inData,
    output logic        outValid,
    input  logic        outReady,
    output logic [33:0] outData,
    output logic        outPort,
    output logic [15:0] dropCount,
    output logic [15:0] pktCount
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned WW = 35;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DROP = 2'd2
    } wstate_e;

    logic [WW-1:0] mem [DEPTH];

    wstate_e       state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic          port_q, port_d;
    logic          out_valid_q;
    logic [33:0]   out_data_q;
    logic          out_port_q;

    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [WW-1:0] mem_wdata_c;
    logic [1:0]    drop_inc_c;
    logic          pkt_inc_c;
    logic          in_sop_c, in_eop_c, addr_hit_c, addr_b_c;
    logic          full_sop_c, full_pkt_c, rd_load_c;

    assign in_eop_c   = inData[33];
    assign in_sop_c   = inData[32];
    assign addr_b_c   = (inData[31:0] == PORTB_ADDR);
    assign addr_hit_c = (inData[31:0] == PORTA_ADDR) || addr_b_c;
    // A new packet always starts at commitPtr (after any rollback), so its fullness is judged from there.
    assign full_sop_c = ((commit_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign full_pkt_c = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign rd_load_c  = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || outReady);

    // Write-side FSM: classify, store, commit or roll back.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        port_d       = port_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = wr_ptr_q[AW-1:0];
        mem_wdata_c  = {port_q, inData};
        drop_inc_c   = 2'd0;
        pkt_inc_c    = 1'b0;
        if (inWrEn) begin
            if (in_sop_c) begin
                if (state_q == W_PKT) begin
                    wr_ptr_d   = commit_ptr_q;
                    drop_inc_c = 2'd1;
                end
                if (!addr_hit_c || full_sop_c) begin
                    drop_inc_c = drop_inc_c + 2'd1;
                    wr_ptr_d   = commit_ptr_q;
                    state_d    = in_eop_c ? W_IDLE : W_DROP;
                end else begin
                    port_d      = addr_b_c;
                    mem_we_c    = 1'b1;
                    mem_waddr_c = commit_ptr_q[AW-1:0];
                    mem_wdata_c = {addr_b_c, inData};
                    wr_ptr_d    = commit_ptr_q + PW'(1);
                    if (in_eop_c) begin
                        commit_ptr_d = commit_ptr_q + PW'(1);
                        pkt_inc_c    = 1'b1;
                        state_d      = W_IDLE;
                    end else begin
                        state_d = W_PKT;
                    end
                end
            end else begin
                case (state_q)
                    W_PKT: begin
                        if (full_pkt_c) begin
                            wr_ptr_d   = commit_ptr_q;
                            drop_inc_c = 2'd1;
                            state_d    = in_eop_c ? W_IDLE : W_DROP;
                        end else begin
                            mem_we_c = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            if (in_eop_c) begin
                                commit_ptr_d = wr_ptr_q + PW'(1);
                                pkt_inc_c    = 1'b1;
                                state_d      = W_IDLE;
                            end
                        end
                    end
                    W_DROP: begin
                        if (in_eop_c) state_d = W_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            port_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            port_q       <= port_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
    end

    // Output register: only committed words are ever visible to egress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= 1'b0;
        end else if (rd_load_c) begin
            rd_ptr_q    <= rd_ptr_q + PW'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= mem[rd_ptr_q[AW-1:0]][33:0];
            out_port_q  <= mem[rd_ptr_q[AW-1:0]][34];
        end else if (outReady) begin
            out_valid_q <= 1'b0;
        end
    end

    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outPort  = out_port_q;

`ifdef ETH_PKT_BUF_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] pkt_cnt_q;
    logic [16:0] drop_sum_c;

    assign drop_sum_c = {1'b0, drop_cnt_q} + 17'(drop_inc_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
            pkt_cnt_q  <= pkt_cnt_q + 16'(pkt_inc_c);
        end
    end

    assign dropCount = drop_cnt_q;
    assign pktCount  = pkt_cnt_q;
`else
    logic unused_stats_c;
    assign unused_stats_c = ^{drop_inc_c, pkt_inc_c};
    assign dropCount      = '0;
    assign pktCount       = '0;
`endif

endmodule

// File: tb/tb_eth_pkt_buffer.sv
// Directed bench for eth_pkt_buffer (DEPTH=8): vector table plus overflow and reset sequences.
module tb_eth_pkt_buffer;

`ifdef ETH_PKT_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inWrEn;
    logic [33:0] inData;
    logic        outValid;
    logic        outReady;
    logic [33:0] outData;
    logic        outPort;
    logic [15:0] dropCount;
    logic [15:0] pktCount;

    int n_cmp = 0;
    int n_err = 0;

    eth_pkt_buffer #(.DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .inWrEn   (inWrEn),
        .inData   (inData),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outPort  (outPort),
        .dropCount(dropCount),
        .pktCount (pktCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [33:0] din;
        logic        rdy;
        logic        ev;
        logic [33:0] ed;
        logic        ep;
    } vec_t;

    localparam int NV = 36;
    vec_t tv [NV];

    function automatic vec_t mk(input logic en, input logic [33:0] din, input logic rdy,
                                input logic ev, input logic [33:0] ed, input logic ep);
        vec_t v;
        v.en = en; v.din = din; v.rdy = rdy; v.ev = ev; v.ed = ed; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic [33:0] din, input logic rdy);
        inWrEn   = en;
        inData   = din;
        outReady = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] out_snap();
        return {28'd0, outValid, outValid ? outPort : 1'b0, outValid ? outData : 34'd0};
    endfunction

    int          k;
    logic [33:0] exp_w [6];

    initial begin
        tv[0]  = mk(1, {2'b01, 32'h0000ABCD}, 1, 0, '0, 0);
        tv[1]  = mk(1, {2'b00, 32'h11111111}, 1, 0, '0, 0);
        tv[2]  = mk(1, {2'b00, 32'h22222222}, 1, 0, '0, 0);
        tv[3]  = mk(1, {2'b10, 32'h33333333}, 1, 0, '0, 0);
        tv[4]  = mk(0, '0, 1, 1, {2'b01, 32'h0000ABCD}, 0);
        tv[5]  = mk(0, '0, 1, 1, {2'b00, 32'h11111111}, 0);
        tv[6]  = mk(0, '0, 1, 1, {2'b00, 32'h22222222}, 0);
        tv[7]  = mk(0, '0, 1, 1, {2'b10, 32'h33333333}, 0);
        tv[8]  = mk(0, '0, 1, 0, '0, 0);
        tv[9]  = mk(1, {2'b11, 32'h0000BEEF}, 1, 0, '0, 0);
        tv[10] = mk(0, '0, 1, 1, {2'b11, 32'h0000BEEF}, 1);
        tv[11] = mk(0, '0, 1, 0, '0, 0);
        tv[12] = mk(1, {2'b01, 32'h00001234}, 1, 0, '0, 0);
        tv[13] = mk(1, {2'b00, 32'h0000AAAA}, 1, 0, '0, 0);
        tv[14] = mk(1, {2'b10, 32'h0000BBBB}, 1, 0, '0, 0);
        tv[15] = mk(1, {2'b01, 32'h0000BEEF}, 1, 0, '0, 0);
        tv[16] = mk(1, {2'b10, 32'h0000CCCC}, 1, 0, '0, 0);
        tv[17] = mk(0, '0, 1, 1, {2'b01, 32'h0000BEEF}, 1);
        tv[18] = mk(0, '0, 1, 1, {2'b10, 32'h0000CCCC}, 1);
        tv[19] = mk(0, '0, 1, 0, '0, 0);
        tv[20] = mk(1, {2'b00, 32'h0000DEAD}, 1, 0, '0, 0);
        tv[21] = mk(0, '0, 1, 0, '0, 0);
        tv[22] = mk(1, {2'b01, 32'h0000ABCD}, 1, 0, '0, 0);
        tv[23] = mk(1, {2'b00, 32'h00000001}, 1, 0, '0, 0);
        tv[24] = mk(1, {2'b00, 32'h00000002}, 1, 0, '0, 0);
        tv[25] = mk(1, {2'b01, 32'h0000BEEF}, 1, 0, '0, 0);
        tv[26] = mk(1, {2'b10, 32'h00000003}, 1, 0, '0, 0);
        tv[27] = mk(0, '0, 1, 1, {2'b01, 32'h0000BEEF}, 1);
        tv[28] = mk(0, '0, 1, 1, {2'b10, 32'h00000003}, 1);
        tv[29] = mk(0, '0, 1, 0, '0, 0);
        tv[30] = mk(1, {2'b11, 32'h0000ABCD}, 0, 0, '0, 0);
        tv[31] = mk(0, '0, 0, 1, {2'b11, 32'h0000ABCD}, 0);
        tv[32] = mk(1, {2'b11, 32'h0000BEEF}, 0, 1, {2'b11, 32'h0000ABCD}, 0);
        tv[33] = mk(0, '0, 0, 1, {2'b11, 32'h0000ABCD}, 0);
        tv[34] = mk(0, '0, 1, 1, {2'b11, 32'h0000BEEF}, 1);
        tv[35] = mk(0, '0, 1, 0, '0, 0);

        reset = 1'b1; inWrEn = 1'b0; inData = '0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(outValid), 64'd0);
        chk("reset_data", 64'(outData), 64'd0);
        chk("reset_port", 64'(outPort), 64'd0);
        chk("reset_cnt", {32'd0, dropCount, pktCount}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            inWrEn   = tv[i].en;
            inData   = tv[i].din;
            outReady = tv[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), out_snap(),
                {28'd0, tv[i].ev, tv[i].ep, tv[i].ed});
        end
        chk("table_pkt", 64'(pktCount), STATS ? 64'd6 : 64'd0);
        chk("table_drop", 64'(dropCount), STATS ? 64'd2 : 64'd0);

        // Overflow: 6-word packet fills DEPTH=8 with output stalled, 5-word follower must drop.
        exp_w[0] = {2'b01, 32'h0000ABCD};
        for (int i = 1; i < 5; i++) exp_w[i] = {2'b00, 32'(i)};
        exp_w[5] = {2'b10, 32'h00000005};
        for (int i = 0; i < 6; i++) step(1'b1, exp_w[i], 1'b0);
        step(1'b1, {2'b01, 32'h0000BEEF}, 1'b0);
        for (int i = 1; i < 4; i++) step(1'b1, {2'b00, 32'h50000000 | 32'(i)}, 1'b0);
        step(1'b1, {2'b10, 32'h50000004}, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("ovf_head", out_snap(), {28'd0, 1'b1, 1'b0, exp_w[0]});
        chk("ovf_drop", 64'(dropCount), STATS ? 64'd3 : 64'd0);
        chk("ovf_pkt", 64'(pktCount), STATS ? 64'd7 : 64'd0);
        inWrEn   = 1'b0;
        outReady = 1'b1;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            if (outValid) begin
                if (k < 6) chk($sformatf("ovf_word%0d", k), out_snap(), {28'd0, 1'b1, 1'b0, exp_w[k]});
                k++;
            end
            @(posedge clk);
            #1;
        end
        chk("ovf_count", 64'(k), 64'd6);

        // Reset while two packets are buffered and the output register is occupied.
        step(1'b1, {2'b11, 32'h0000ABCD}, 1'b0);
        step(1'b1, {2'b11, 32'h0000BEEF}, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("pre_rst_valid", out_snap(), {28'd0, 1'b1, 1'b0, 2'b11, 32'h0000ABCD});
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(outValid), 64'd0);
        chk("async_rst_data", 64'(outData), 64'd0);
        chk("async_rst_cnt", {32'd0, dropCount, pktCount}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, {2'b11, 32'h0000BEEF}, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("post_rst_word", out_snap(), {28'd0, 1'b1, 1'b1, 2'b11, 32'h0000BEEF});
        step(1'b0, '0, 1'b1);
        chk("post_rst_empty", 64'(outValid), 64'd0);
        chk("post_rst_pkt", 64'(pktCount), STATS ? 64'd1 : 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
